// File: rtl/uc_tx_frame.sv
// uc_tx_frame: UART transmit framer.
// Sends one byte per frame: a start bit, 5-8 data bits LSB first, an optional
// parity bit, then 1 or 2 stop bits. It advances one bit per bd_tick from the
// baud generator and keeps bd_en high for the whole frame.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   tx_data, tx_valid   byte to send plus valid; accepted when tx_ready is high
//   tx_ready            high only while idle
//   cfg_*               frame format; captured together with the byte
//   bd_en, bd_tick      enable out to the baud generator, bit pulse back from it
//   tx                  registered serial line
//   busy, frame_done    frame in progress; one-cycle pulse once a frame ends
//
// state  | meaning
// IDLE   | line idle, waiting for a byte
// ARM    | baud generator enabled, line still idle until the first tick
// START  | start bit on the line
// DATA   | data bits on the line
// PARITY | parity bit on the line
// STOP1  | first stop bit on the line
// STOP2  | second stop bit on the line
module uc_tx_frame #(
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        cfg_data_bits,
  input  logic              cfg_parity_en,
  input  logic              cfg_parity_odd,
  input  logic              cfg_stop2,
  output logic              bd_en,
  input  logic              bd_tick,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        last_q, last_d;     // index of the final data bit (N-1)
  logic [2:0]        idx_q, idx_d;       // index of the data bit now on the line
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] data_mask;
  logic              parity_bit;

  // Only the configured number of data bits feed the parity.
  assign data_mask  = {DATA_W{1'b1}} >> (3'd7 - last_q);
  assign parity_bit = (^(data_q & data_mask)) ^ par_odd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      last_q    <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    last_d    = last_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d  = IDLE_LEVEL;
        idx_d = '0;
        if (tx_valid) begin
          data_d    = tx_data;
          last_d    = {1'b0, cfg_data_bits} + 3'd4;
          par_en_d  = cfg_parity_en;
          par_odd_d = cfg_parity_odd;
          stop2_d   = cfg_stop2;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (bd_tick) begin
          tx_d    = ~IDLE_LEVEL;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bd_tick) begin
          tx_d    = data_q[0];
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Tracking the index of the bit on the line (not the next one) keeps
        // the counter within 0..7 even for 8-bit frames.
        if (bd_tick) begin
          if (idx_q != last_q) begin
            tx_d  = data_q[idx_q + 3'd1];
            idx_d = idx_q + 3'd1;
          end else if (par_en_q) begin
            tx_d    = parity_bit;
            state_d = ST_PARITY;
          end else begin
            tx_d    = IDLE_LEVEL;
            state_d = ST_STOP1;
          end
        end
      end
      ST_PARITY: begin
        if (bd_tick) begin
          tx_d    = IDLE_LEVEL;
          state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (bd_tick) begin
          if (stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (bd_tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign bd_en      = busy;
  assign tx         = tx_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uc_tx_frame.sv
module tb_uc_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic       bd_en;
  logic       bd_tick;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uc_tx_frame #(.IDLE_LEVEL(1'b1), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2(cfg_stop2), .bd_en(bd_en), .bd_tick(bd_tick), .tx(tx),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  db;
    logic        pe;
    logic        po;
    logic        s2;
    int          period;
    bit          scr;
    logic [11:0] bits;   // line bits in send order, bit 0 first
    int          n;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic step(input logic tk);
    bd_tick = tk;
    @(negedge clk);
    bd_tick = 1'b0;
  endtask

  // Reference: the frame as a list of line levels, built from the format rules.
  function automatic void model(input logic [7:0] d, input logic [1:0] db,
                                input logic pe, input logic po, input logic s2,
                                output logic [11:0] bits, output int n);
    int nd;
    int ones;
    nd = int'(db) + 5;
    ones = 0;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nd; i++) begin
      bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (pe) begin
      bits[n] = ((ones % 2) == 1) ^ po;
      n++;
    end
    bits[n] = 1'b1; n++;
    if (s2) begin
      bits[n] = 1'b1; n++;
    end
  endfunction

  task automatic run_frame(input logic [7:0] d, input logic [1:0] db, input logic pe,
                           input logic po, input logic s2, input int period,
                           input bit scr, input logic [11:0] exp_bits, input int exp_n);
    logic cur;
    chk("ready_before_frame", tx_ready, 1);
    tx_data = d; cfg_data_bits = db; cfg_parity_en = pe;
    cfg_parity_odd = po; cfg_stop2 = s2; tx_valid = 1'b1;
    step(1'b0);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk("arm_bd_en", bd_en, 1);
    chk("arm_busy", busy, 1);
    chk("arm_tx_idle", tx, 1);
    cur = 1'b1;
    for (int k = 0; k <= exp_n; k++) begin
      for (int c = 1; c < period; c++) begin
        step(1'b0);
        chk("bit_hold", tx, cur);
        chk("no_early_done", frame_done, 0);
      end
      if (scr && k == 4) begin
        cfg_data_bits = ~db; cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b1; cfg_stop2 = 1'b1;
      end
      step(1'b1);
      if (k < exp_n) begin
        cur = exp_bits[k];
        chk("bit_value", tx, cur);
        chk("busy_in_frame", busy, 1);
        chk("bd_en_in_frame", bd_en, 1);
        chk("no_early_done", frame_done, 0);
      end else begin
        chk("done_pulse", frame_done, 1);
        chk("done_busy_low", busy, 0);
        chk("done_ready", tx_ready, 1);
        chk("done_bd_en_low", bd_en, 0);
        chk("done_tx_idle", tx, 1);
      end
    end
    step(1'b0);
    chk("done_single_cycle", frame_done, 0);
  endtask

  initial begin
    logic [11:0] mb;
    int          mn;
    int          frames;
    logic        prev_done;
    bit          idle_seen;

    tbl[0] = '{d:8'hA5, db:2'd3, pe:1'b0, po:1'b0, s2:1'b0, period:8, scr:1'b0, bits:12'h34A, n:10};
    tbl[1] = '{d:8'hC1, db:2'd2, pe:1'b1, po:1'b0, s2:1'b0, period:4, scr:1'b0, bits:12'h282, n:10};
    tbl[2] = '{d:8'h5A, db:2'd3, pe:1'b0, po:1'b0, s2:1'b0, period:3, scr:1'b1, bits:12'h2B4, n:10};
    tbl[3] = '{d:8'hFF, db:2'd0, pe:1'b1, po:1'b1, s2:1'b1, period:5, scr:1'b0, bits:12'h1BE, n:9};
    tbl[4] = '{d:8'h3C, db:2'd1, pe:1'b1, po:1'b0, s2:1'b1, period:2, scr:1'b0, bits:12'h378, n:10};
    tbl[5] = '{d:8'h00, db:2'd3, pe:1'b1, po:1'b1, s2:1'b0, period:1, scr:1'b0, bits:12'h600, n:11};

    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b1; bd_tick = 1'b0;
    cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    @(negedge clk);
    step(1'b1);
    step(1'b0);
    chk("rst_tx", tx, 1);
    chk("rst_bd_en", bd_en, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    tx_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(i[0]);
      chk("idle_tick_tx", tx, 1);
      chk("idle_tick_bd_en", bd_en, 0);
      chk("idle_tick_busy", busy, 0);
      chk("idle_tick_ready", tx_ready, 1);
      chk("idle_tick_done", frame_done, 0);
    end

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].d, tbl[i].db, tbl[i].pe, tbl[i].po, tbl[i].s2,
                tbl[i].period, tbl[i].scr, tbl[i].bits, tbl[i].n);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic [1:0] db;
      logic pe, po, s2;
      d  = 8'($urandom);
      db = 2'($urandom);
      pe = 1'($urandom);
      po = 1'($urandom);
      s2 = 1'($urandom);
      model(d, db, pe, po, s2, mb, mn);
      run_frame(d, db, pe, po, s2, int'($urandom_range(1, 5)), 1'b0, mb, mn);
    end

    // Reset in the middle of the data bits aborts the frame.
    tx_data = 8'h00; cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    tx_valid = 1'b1;
    step(1'b0);
    tx_valid = 1'b0;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("pre_abort_tx", tx, 0);
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk("abort_tx", tx, 1);
    chk("abort_bd_en", bd_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", tx_ready, 1);
    chk("abort_done", frame_done, 0);
    for (int i = 0; i < 12; i++) begin
      step(i[0]);
      chk("post_abort_done", frame_done, 0);
      chk("post_abort_tx", tx, 1);
    end

    // tx_valid held high: frames run back to back with an idle gap.
    tx_data = 8'h6B; cfg_data_bits = 2'd0; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    tx_valid = 1'b1;
    frames = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 150; c++) begin
      step(c[0]);
      chk("b2b_ready_vs_bd_en", tx_ready, !bd_en);
      if (prev_done) begin
        chk("b2b_reaccept", bd_en, 1);
        chk("b2b_done_single", frame_done, 0);
      end
      if (frame_done) begin
        frames++;
        chk("b2b_gap_bd_en", bd_en, 0);
        chk("b2b_gap_busy", busy, 0);
      end
      prev_done = frame_done;
    end
    chk("b2b_frames", frames >= 4, 1);
    tx_valid = 1'b0;
    idle_seen = 1'b0;
    for (int c = 0; c < 100 && !idle_seen; c++) begin
      step(1'b1);
      if (!busy) idle_seen = 1'b1;
    end
    chk("drain_to_idle", idle_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
